// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC sequencer with req/ack imem handshake, decode stall hold,
// and branch/jump redirect with a counted flush.
// Optional build macro PC_ALIGN_CHECK_EN: reject misaligned redirect targets and raise
// a sticky addr_err_o. Without it, the low two target bits are cleared instead.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_valid_i,
  input  logic [1:0]  flag_i,
  input  logic [31:0] jump_address_i,
  input  logic [31:0] branch_pc_i,
  input  logic [15:0] branch_imm_i,
  input  logic        stall_i,
  input  logic        imem_ack_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic        flush_o,
  output logic        addr_err_o,
  output logic [15:0] redirect_cnt_o
);
  typedef enum logic [1:0] {FETCH, STALL, DRAIN, FLUSH} state_e;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  state_e      state_q;
  logic [31:0] pc_q, pending_q, if_pc_q;
  logic [31:0] bpc4, br_tgt, j_tgt, raw_tgt, tgt;
  logic [3:0]  fcnt_q;
  logic [15:0] redirect_cnt_q;
  logic        if_valid_q, flush_q, accept;
  // Redirect target for each flag encoding; arithmetic wraps mod 2^32.
  always_comb begin
    bpc4    = branch_pc_i + 32'd4;
    br_tgt  = bpc4 + {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00};
    j_tgt   = {bpc4[31:28], jump_address_i[25:0], 2'b00};
    raw_tgt = flag_i[1] ? (flag_i[0] ? jump_address_i : j_tgt) : br_tgt;
  end
`ifdef PC_ALIGN_CHECK_EN
  logic misalign, addr_err_q;
  assign misalign   = raw_tgt[1:0] != 2'b00;
  assign tgt        = raw_tgt;
  assign accept     = redirect_valid_i && !misalign;
  assign addr_err_o = addr_err_q;
  // Sticky flag recording any rejected misaligned redirect.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) addr_err_q <= 1'b0;
    else if (redirect_valid_i && misalign) addr_err_q <= 1'b1;
  end
`else
  assign tgt        = raw_tgt & ~32'h3;
  assign accept     = redirect_valid_i;
  assign addr_err_o = 1'b0;
`endif
  // Saturating count of accepted redirects.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) redirect_cnt_q <= '0;
    else if (accept && redirect_cnt_q != 16'hFFFF) redirect_cnt_q <= redirect_cnt_q + 16'd1;
  end
  // Fetch sequencer; a redirect always wins over normal fetch progress.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      pending_q  <= '0;
      fcnt_q     <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      flush_q    <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (accept) begin
            if_valid_q <= 1'b0;
            flush_q    <= 1'b1;
            if (imem_ack_i) begin
              pc_q    <= tgt;
              fcnt_q  <= FLUSH_LOAD;
              state_q <= FLUSH;
            end else begin
              pending_q <= tgt;
              state_q   <= DRAIN;
            end
          end else if (imem_ack_i) begin
            if_valid_q <= 1'b1;
            if_pc_q    <= pc_q;
            pc_q       <= pc_q + 32'd4;
            state_q    <= stall_i ? STALL : FETCH;
          end else begin
            if_valid_q <= 1'b0;
          end
        end
        STALL: begin
          if (accept) begin
            if_valid_q <= 1'b0;
            flush_q    <= 1'b1;
            pc_q       <= tgt;
            fcnt_q     <= FLUSH_LOAD;
            state_q    <= FLUSH;
          end else if (!stall_i) begin
            if_valid_q <= 1'b0;
            state_q    <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack_i) begin
            pc_q    <= accept ? tgt : pending_q;
            fcnt_q  <= FLUSH_LOAD;
            state_q <= FLUSH;
          end else if (accept) begin
            pending_q <= tgt;
          end
        end
        FLUSH: begin
          if (accept) begin
            pc_q   <= tgt;
            fcnt_q <= FLUSH_LOAD;
          end else if (fcnt_q == 4'd0) begin
            flush_q <= 1'b0;
            state_q <= FETCH;
          end else begin
            fcnt_q <= fcnt_q - 4'd1;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end
  assign imem_req_o     = rst_ni && (state_q == FETCH || state_q == DRAIN);
  assign imem_addr_o    = pc_q;
  assign if_valid_o     = if_valid_q;
  assign if_pc_o        = if_pc_q;
  assign flush_o        = flush_q;
  assign redirect_cnt_o = redirect_cnt_q;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed-vector bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, rv, stall, ack;
  logic [1:0]  flag;
  logic [31:0] ja, bpc;
  logic [15:0] imm;
  logic        imem_req, if_valid, flush, addr_err;
  logic [31:0] imem_addr, if_pc;
  logic [15:0] redirect_cnt;
  int          n_chk = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  pc_redirect_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .redirect_valid_i(rv), .flag_i(flag),
    .jump_address_i(ja), .branch_pc_i(bpc), .branch_imm_i(imm), .stall_i(stall),
    .imem_ack_i(ack), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .if_valid_o(if_valid), .if_pc_o(if_pc), .flush_o(flush),
    .addr_err_o(addr_err), .redirect_cnt_o(redirect_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0; rv = 1'b0; stall = 1'b0; ack = 1'b0;
    flag = 2'b00; ja = '0; bpc = '0; imm = '0;
    tick();
    tick();
    chk("rst_req", imem_req, 0);
    chk("rst_vld", if_valid, 0);
    chk("rst_ifpc", if_pc, 0);
    chk("rst_flush", flush, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_cnt", redirect_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
  endtask
  task automatic redir_ack(input logic [1:0] f, input logic [31:0] b, input logic [15:0] i,
                           input logic [31:0] j, input logic [31:0] tgt, input logic [15:0] cnt);
    ack = 1'b1; rv = 1'b1; flag = f; bpc = b; imm = i; ja = j;
    tick();
    rv = 1'b0;
    chk("rd_flush1", flush, 1);
    chk("rd_vld", if_valid, 0);
    chk("rd_req1", imem_req, 0);
    chk("rd_cnt", redirect_cnt, 32'(cnt));
    tick();
    chk("rd_flush2", flush, 1);
    chk("rd_req2", imem_req, 0);
    tick();
    chk("rd_flush_end", flush, 0);
    chk("rd_req3", imem_req, 1);
    chk("rd_tgt", imem_addr, tgt);
    tick();
    chk("rd_vld2", if_valid, 1);
    chk("rd_ifpc", if_pc, tgt);
  endtask
  initial begin
    do_reset();
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", imem_addr, 32'(i * 4));
      chk("seq_req", imem_req, 1);
      tick();
      chk("seq_vld", if_valid, 1);
      chk("seq_ifpc", if_pc, 32'(i * 4));
      chk("seq_flush", flush, 0);
    end
    redir_ack(2'b00, 32'h0000_0040, 16'hFFFE, 32'h0, 32'h0000_003C, 16'd1);
    redir_ack(2'b10, 32'hF000_0010, 16'h0, 32'h0000_0100, 32'hF000_0400, 16'd2);
    redir_ack(2'b11, 32'h0, 16'h0, 32'h1234_5678, 32'h1234_5678, 16'd3);
    ack = 1'b0; rv = 1'b1; flag = 2'b11; ja = 32'h80;
    tick();
    chk("dr_flush", flush, 1);
    chk("dr_vld", if_valid, 0);
    chk("dr_req", imem_req, 1);
    chk("dr_addr", imem_addr, 32'h1234_567C);
    chk("dr_cnt1", redirect_cnt, 4);
    ja = 32'hC0;
    tick();
    rv = 1'b0;
    chk("dr_cnt2", redirect_cnt, 5);
    chk("dr_addr2", imem_addr, 32'h1234_567C);
    tick();
    chk("dr_hold_req", imem_req, 1);
    chk("dr_hold_flush", flush, 1);
    ack = 1'b1;
    tick();
    chk("dr_ack_req", imem_req, 0);
    chk("dr_ack_vld", if_valid, 0);
    chk("dr_ack_flush", flush, 1);
    tick();
    chk("dr_fl2", flush, 1);
    tick();
    chk("dr_end_flush", flush, 0);
    chk("dr_resume", imem_addr, 32'hC0);
    tick();
    chk("dr_ifpc", if_pc, 32'hC0);
    chk("dr_ifvld", if_valid, 1);
    do_reset();
    ack = 1'b1;
    tick();
    tick();
    stall = 1'b1;
    tick();
    chk("st_req", imem_req, 0);
    chk("st_vld", if_valid, 1);
    chk("st_ifpc", if_pc, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_req", imem_req, 0);
      chk("st_hold_vld", if_valid, 1);
      chk("st_hold_pc", if_pc, 32'h8);
    end
    stall = 1'b0;
    tick();
    chk("st_rel_vld", if_valid, 0);
    chk("st_rel_req", imem_req, 1);
    chk("st_rel_addr", imem_addr, 32'hC);
    stall = 1'b1;
    tick();
    chk("st2_ifpc", if_pc, 32'hC);
    stall = 1'b0; rv = 1'b1; flag = 2'b11; ja = 32'h200;
    tick();
    rv = 1'b0;
    chk("st_rd_vld", if_valid, 0);
    chk("st_rd_flush", flush, 1);
    chk("st_rd_cnt", redirect_cnt, 1);
    tick();
    chk("st_rd_flush2", flush, 1);
    tick();
    chk("st_rd_req", imem_req, 1);
    chk("st_rd_addr", imem_addr, 32'h200);
    rv = 1'b1; ja = 32'h102;
    tick();
    rv = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_err", addr_err, 1);
    chk("mis_flush", flush, 0);
    chk("mis_vld", if_valid, 1);
    chk("mis_ifpc", if_pc, 32'h200);
    chk("mis_addr", imem_addr, 32'h204);
    chk("mis_cnt", redirect_cnt, 1);
`else
    chk("mis_err", addr_err, 0);
    chk("mis_flush", flush, 1);
    chk("mis_cnt", redirect_cnt, 2);
    tick();
    tick();
    chk("mis_req", imem_req, 1);
    chk("mis_addr", imem_addr, 32'h100);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
